fm_accum_writer: RTL and testbench
==================================

// Module: fm_accum_writer
// PURPOSE
//  Write-side initiator for the float16 feature-map RAM. Accepts PARA_Y-wide MAC partial-sum words
//  over a valid/ready stream and drives the RAM write port.
//  For each output tile it runs cfg_passes input-channel passes over row addresses 0..cfg_last_addr.
//  Pass 0 overwrites the stored word; later passes use the RAM's 2-cycle read-add-write (write_ready).
// PARAMETERS
//  DATA_WIDTH        16  bits per float16 element
//  PARA_Y            3   elements per RAM word (MACs per group)
//  WRITE_ADDR_WIDTH  3   RAM word-address width
//  PASS_WIDTH        8   width of the pass counter and cfg_passes
// PORTS
//  clk            in   1                    system clock, all logic on posedge
//  rst            in   1                    asynchronous, active-high reset
//  start          in   1                    1-cycle pulse; latches cfg_*; ignored while busy
//  cfg_last_addr  in   WRITE_ADDR_WIDTH     last row address of the tile (inclusive)
//  cfg_passes     in   PASS_WIDTH           number of accumulation passes; 0 is treated as 1
//  s_valid        in   1                    partial-sum word valid
//  s_ready        out  1                    block accepts s_data this cycle
//  s_data         in   PARA_Y*DATA_WIDTH    partial sums; element k at [DATA_WIDTH*(k+1)-1 : DATA_WIDTH*k]
//  ena_w          out  1                    RAM write enable
//  ena_add_write  out  1                    RAM accumulate select: 0 = overwrite, 1 = add
//  addr_write     out  WRITE_ADDR_WIDTH     RAM word address
//  din            out  PARA_Y*DATA_WIDTH    RAM write data
//  write_ready    in   1                    RAM add-complete flag (registered inside the RAM)
//  busy           out  1                    high from start-accept until done
//  pass_idx       out  PASS_WIDTH           current pass number
//  done           out  1                    1-cycle pulse when the final word is committed
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, counters 0.
//  - A reset during ADD0/ADD1 can leave the RAM's internal add phase at 1.
//  - The system reset therefore also reloads the RAM; this block does not compensate.
//  All outputs are registered. States: IDLE, ACCEPT, PLAIN, ADD0, ADD1, ADDWAIT, DONE.
//  IDLE: on start, latch the config; addr = 0, pass = 0, busy = 1; go to ACCEPT.
//  ACCEPT: s_ready = 1, ena_w = 0. On s_valid:
//  - Register din = s_data, addr_write = addr, ena_w = 1, ena_add_write = (pass != 0).
//  - Go to PLAIN if pass == 0, else to ADD0.
//  PLAIN: ena_w high exactly this cycle (RAM stores at the closing edge); then ADVANCE.
//  ADD0: ena_w = ena_add_write = 1; RAM captures its operands. Go to ADD1.
//  ADD1: ena_w still 1; RAM commits the sum and raises write_ready. Drop ena_w; go to ADDWAIT.
//  ADDWAIT: ena_w = 0; hold addr_write and din. On write_ready == 1, ADVANCE.
//  - write_ready is never sampled in ADD0/ADD1, because it may still be 1 from the previous add.
//  ADVANCE (same edge as leaving PLAIN/ADDWAIT):
//  - If addr < last: addr++ and go to ACCEPT.
//  - Else addr = 0. If pass == passes-1, go to DONE; otherwise pass++ and go to ACCEPT.
//  DONE: done = 1 for one cycle, busy = 0; go to IDLE.
//  Throughput: 2 cycles per word in pass 0; 4 cycles per word (minimum) in later passes.
//  Boundaries:
//  - s_ready is 0 in every state except ACCEPT; s_data is never sampled elsewhere.
//  - start while busy is ignored; start coinciding with the DONE cycle is ignored.
//  - cfg_last_addr = 0 gives a single-word tile; passes = 1 means no add cycles occur.
//  - addr_write is never driven beyond cfg_last_addr.
//  - ena_w and ena_add_write are never both high outside PLAIN/ADD0/ADD1.
// STRUCTURE
//  Shared package fm_pkg: DATA_WIDTH, PARA_Y, WRITE_ADDR_WIDTH, PASS_WIDTH defines and the state encodings.
//  Single module. The address/pass counter pair may be split out as fm_tile_counter (wrap plus
//  pass increment); it is otherwise inline.
// TESTING  (bench pairs the block with a behavioural model of the float16 add RAM)
//  1. last=2, passes=1, words {1.0,2.0,3.0}x3 (0x3C00,0x4000,0x4200)
//     -> 3 plain writes to addr 0,1,2; ena_add_write never 1; done 6 cycles after the first handshake.
//  2. last=1, passes=3, every element 0x3C00 (1.0)
//     -> RAM holds 0x4200 (3.0) in all elements; each add holds ena_w for exactly 2 cycles; done once.
//  3. s_valid gapped randomly during test 2 -> identical RAM contents; s_ready only in ACCEPT.
//  4. Delay write_ready by 5 extra cycles in the model
//     -> ADDWAIT holds addr_write and din stable; no new handshake until write_ready = 1.
//  5. cfg_passes = 0, last = 0 -> behaves as passes = 1, with 1 plain write then done.
//     start pulsed while busy -> no effect.
//  6. Assert rst mid-ADDWAIT -> all outputs 0 asynchronously; the next start runs a clean tile.

Source files
------------

// File: rtl/fm_pkg.sv
// Shared definitions for the float16 feature-map write path.
//   DATA_WIDTH        bits per float16 element
//   PARA_Y            elements per RAM word
//   WRITE_ADDR_WIDTH  RAM word-address width
//   PASS_WIDTH        width of the pass counter and of cfg_passes
// Also holds the writer state encoding and a helper that turns a pass
// count into the index of the final pass.
package fm_pkg;

  localparam int DATA_WIDTH       = 16;
  localparam int PARA_Y           = 3;
  localparam int WRITE_ADDR_WIDTH = 3;
  localparam int PASS_WIDTH       = 8;
  localparam int WORD_WIDTH       = DATA_WIDTH * PARA_Y;

  typedef logic [WRITE_ADDR_WIDTH-1:0] addr_t;
  typedef logic [PASS_WIDTH-1:0]       pass_t;
  typedef logic [WORD_WIDTH-1:0]       word_t;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ACCEPT  = 3'd1,
    S_PLAIN   = 3'd2,
    S_ADD0    = 3'd3,
    S_ADD1    = 3'd4,
    S_ADDWAIT = 3'd5,
    S_DONE    = 3'd6
  } wr_state_t;

  // A pass count of 0 runs a single pass, exactly like a count of 1.
  function automatic pass_t last_pass_of(input pass_t passes);
    return (passes == '0) ? '0 : passes - pass_t'(1);
  endfunction

endpackage

// File: rtl/fm_tile_counter.sv
// Row-address / pass counter pair for one output tile.
// Ports:
//   clk, rst      clock and asynchronous active-high reset
//   clear         restart the tile at addr 0, pass 0
//   step          one word committed: advance the address, wrapping into
//                 the next pass after last_addr
//   last_addr     final row address of the tile (inclusive)
//   last_pass     index of the final pass
//   addr, pass    current row address and pass number
//   last_word     current word is the final one of the tile
module fm_tile_counter
  import fm_pkg::*;
(
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        clear,
  input  logic                        step,
  input  logic [WRITE_ADDR_WIDTH-1:0] last_addr,
  input  logic [PASS_WIDTH-1:0]       last_pass,
  output logic [WRITE_ADDR_WIDTH-1:0] addr,
  output logic [PASS_WIDTH-1:0]       pass,
  output logic                        last_word
);

  assign last_word = (addr == last_addr) && (pass == last_pass);

  // NOTE: state registers use non-blocking assignments so every flop
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr <= '0;
      pass <= '0;
    end else if (clear) begin
      addr <= '0;
      pass <= '0;
    end else if (step) begin
      if (addr < last_addr) begin
        addr <= addr + addr_t'(1);
      end else begin
        addr <= '0;
        // On the final word the pass number is left at the last pass so
        // pass_idx still reports it while the tile completes.
        if (pass != last_pass) begin
          pass <= pass + pass_t'(1);
        end
      end
    end
  end

endmodule

// File: rtl/fm_accum_writer.sv
// Write-side initiator for the float16 feature-map RAM.
// Takes PARA_Y-wide partial-sum words over a valid/ready stream and drives
// the RAM write port, running cfg_passes passes over rows 0..cfg_last_addr.
// Pass 0 overwrites a row; later passes use the RAM's two-cycle
// read-add-write and then wait for its write_ready flag.
// Ports:
//   clk, rst                clock, asynchronous active-high reset
//   start                   1-cycle pulse, latches cfg_*; ignored while busy
//   cfg_last_addr           last row address of the tile (inclusive)
//   cfg_passes              number of passes (0 behaves as 1)
//   s_valid/s_ready/s_data  partial-sum stream (element k at bits 16k+15:16k)
//   ena_w, ena_add_write    RAM write enable and accumulate select
//   addr_write, din         RAM word address and write data
//   write_ready             RAM add-complete flag
//   busy, pass_idx, done    status: tile in progress, current pass, finish pulse
module fm_accum_writer
  import fm_pkg::*;
(
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [WRITE_ADDR_WIDTH-1:0] cfg_last_addr,
  input  logic [PASS_WIDTH-1:0]       cfg_passes,
  input  logic                        s_valid,
  output logic                        s_ready,
  input  logic [WORD_WIDTH-1:0]       s_data,
  output logic                        ena_w,
  output logic                        ena_add_write,
  output logic [WRITE_ADDR_WIDTH-1:0] addr_write,
  output logic [WORD_WIDTH-1:0]       din,
  input  logic                        write_ready,
  output logic                        busy,
  output logic [PASS_WIDTH-1:0]       pass_idx,
  output logic                        done
);

  wr_state_t state;
  addr_t     last_addr_q;
  pass_t     last_pass_q;
  addr_t     addr;
  pass_t     pass;
  logic      last_word;
  logic      cnt_clear;
  logic      cnt_step;

  // The counters move on the same edge the FSM leaves PLAIN or ADDWAIT,
  // so the decision below always sees the address of the word just written.
  // write_ready is only looked at in ADDWAIT: in ADD0/ADD1 it can still be
  // high from the previous add.
  assign cnt_clear = (state == S_IDLE) && start;
  assign cnt_step  = (state == S_PLAIN) || ((state == S_ADDWAIT) && write_ready);

  fm_tile_counter u_tile_counter (
    .clk       (clk),
    .rst       (rst),
    .clear     (cnt_clear),
    .step      (cnt_step),
    .last_addr (last_addr_q),
    .last_pass (last_pass_q),
    .addr      (addr),
    .pass      (pass),
    .last_word (last_word)
  );

  assign pass_idx = pass;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= S_IDLE;
      last_addr_q   <= '0;
      last_pass_q   <= '0;
      s_ready       <= 1'b0;
      ena_w         <= 1'b0;
      ena_add_write <= 1'b0;
      addr_write    <= '0;
      din           <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (start) begin
            last_addr_q <= cfg_last_addr;
            last_pass_q <= last_pass_of(cfg_passes);
            busy        <= 1'b1;
            s_ready     <= 1'b1;
            state       <= S_ACCEPT;
          end
        end

        S_ACCEPT: begin
          if (s_valid) begin
            din           <= s_data;
            addr_write    <= addr;
            ena_w         <= 1'b1;
            ena_add_write <= (pass != '0);
            s_ready       <= 1'b0;
            state         <= (pass == '0) ? S_PLAIN : S_ADD0;
          end
        end

        // RAM captures its operands while ena_w/ena_add_write are high.
        S_ADD0: state <= S_ADD1;

        // RAM commits the sum at the closing edge of this cycle.
        S_ADD1: begin
          ena_w         <= 1'b0;
          ena_add_write <= 1'b0;
          state         <= S_ADDWAIT;
        end

        // PLAIN always advances after its single write cycle; ADDWAIT holds
        // addr_write/din until the RAM reports the add complete.
        S_PLAIN, S_ADDWAIT: begin
          if (cnt_step) begin
            ena_w <= 1'b0;
            if (last_word) begin
              done  <= 1'b1;
              busy  <= 1'b0;
              state <= S_DONE;
            end else begin
              s_ready <= 1'b1;
              state   <= S_ACCEPT;
            end
          end
        end

        // start is deliberately not looked at here.
        S_DONE: state <= S_IDLE;

        default: begin
          s_ready       <= 1'b0;
          ena_w         <= 1'b0;
          ena_add_write <= 1'b0;
          busy          <= 1'b0;
          state         <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fm_accum_writer.sv
// Directed bench for fm_accum_writer, paired with a behavioural float16
// add RAM (two-cycle read-add-write, registered write_ready with optional
// extra latency).
module tb_fm_accum_writer;
  import fm_pkg::*;

  logic                        clk = 1'b0;
  logic                        rst;
  logic                        start;
  logic [WRITE_ADDR_WIDTH-1:0] cfg_last_addr;
  logic [PASS_WIDTH-1:0]       cfg_passes;
  logic                        s_valid;
  logic                        s_ready;
  logic [WORD_WIDTH-1:0]       s_data;
  logic                        ena_w;
  logic                        ena_add_write;
  logic [WRITE_ADDR_WIDTH-1:0] addr_write;
  logic [WORD_WIDTH-1:0]       din;
  logic                        write_ready;
  logic                        busy;
  logic [PASS_WIDTH-1:0]       pass_idx;
  logic                        done;

  localparam word_t ONES   = {3{16'h3C00}};
  localparam word_t TWOS   = {3{16'h4000}};
  localparam word_t THREES = {3{16'h4200}};
  localparam word_t JUNK   = {3{16'hBAD0}};

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  fm_accum_writer dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .cfg_last_addr (cfg_last_addr),
    .cfg_passes    (cfg_passes),
    .s_valid       (s_valid),
    .s_ready       (s_ready),
    .s_data        (s_data),
    .ena_w         (ena_w),
    .ena_add_write (ena_add_write),
    .addr_write    (addr_write),
    .din           (din),
    .write_ready   (write_ready),
    .busy          (busy),
    .pass_idx      (pass_idx),
    .done          (done)
  );

  // ---------------- float16 add RAM model ----------------
  function automatic logic [15:0] fp16_add(input logic [15:0] a, input logic [15:0] b);
    logic [15:0] x, y;
    logic [4:0]  e;
    logic [11:0] mx, my, s;
    int          sh;
    if (a[14:0] == 15'd0) return b;
    if (b[14:0] == 15'd0) return a;
    if (a[14:10] >= b[14:10]) begin x = a; y = b; end
    else begin x = b; y = a; end
    e  = x[14:10];
    sh = int'(x[14:10]) - int'(y[14:10]);
    mx = {2'b01, x[9:0]};
    my = (sh > 11) ? 12'd0 : ({2'b01, y[9:0]} >> sh);
    s  = mx + my;
    if (s[11]) begin s = s >> 1; e = e + 5'd1; end
    return {1'b0, e, s[9:0]};
  endfunction

  function automatic word_t add_word(input word_t a, input word_t b);
    word_t r;
    for (int k = 0; k < PARA_Y; k++)
      r[k*DATA_WIDTH +: DATA_WIDTH] = fp16_add(a[k*DATA_WIDTH +: DATA_WIDTH], b[k*DATA_WIDTH +: DATA_WIDTH]);
    return r;
  endfunction

  word_t mem [0:7];
  logic  phase;
  word_t op_a, op_b;
  addr_t op_addr;
  int    wr_cnt;
  int    wr_delay;
  logic  mem_clear;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      phase       <= 1'b0;
      write_ready <= 1'b0;
      wr_cnt      <= 0;
    end else if (mem_clear) begin
      for (int i = 0; i < 8; i++) mem[i] <= '0;
    end else begin
      if (wr_cnt != 0) begin
        wr_cnt <= wr_cnt - 1;
        if (wr_cnt == 1) write_ready <= 1'b1;
      end
      if (ena_w && !ena_add_write) begin
        mem[addr_write] <= din;
      end else if (ena_w && ena_add_write) begin
        if (!phase) begin
          phase       <= 1'b1;
          op_a        <= mem[addr_write];
          op_b        <= din;
          op_addr     <= addr_write;
          write_ready <= 1'b0;
        end else begin
          phase         <= 1'b0;
          mem[op_addr]  <= add_word(op_a, op_b);
          if (wr_delay == 0) write_ready <= 1'b1;
          else               wr_cnt      <= wr_delay;
        end
      end
    end
  end

  // ---------------- protocol monitor (samples on negedge) ----------------
  int    cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  int    exp_wait = 1;
  int    last_exp = 0;
  int    hs_cycs[$];
  addr_t plain_addrs[$];
  int    hs_cnt = 0, done_cnt = 0, done_cyc = 0, plain_cnt = 0, addw_cnt = 0;
  int    add_runs = 0, add_len_err = 0, plain_len_err = 0, sready_err = 0, addr_err = 0;
  int    hold_err = 0, early_err = 0, wait_len_err = 0;
  int    add_run = 0, wait_len = 0;
  logic  in_wait = 1'b0, prev_wr = 1'b0, prev_plain = 1'b0;
  addr_t held_addr;
  word_t held_din;

  always @(negedge clk) begin
    if (rst) begin
      add_run = 0; in_wait = 1'b0; prev_wr = 1'b0; prev_plain = 1'b0;
    end else begin
      if (s_ready && (ena_w || done || !busy)) sready_err++;
      if (s_valid && s_ready) begin hs_cnt++; hs_cycs.push_back(cyc); end
      if (done) begin done_cnt++; done_cyc = cyc; end
      if (ena_add_write) addw_cnt++;
      if (ena_w && (int'(addr_write) > last_exp)) addr_err++;
      if (ena_w && !ena_add_write) begin
        plain_cnt++;
        plain_addrs.push_back(addr_write);
        if (prev_plain) plain_len_err++;
      end
      prev_plain = ena_w && !ena_add_write;
      if (ena_w && ena_add_write) begin
        add_run++;
        held_addr = addr_write;
        held_din  = din;
      end else if (add_run != 0) begin
        add_runs++;
        if (add_run != 2) add_len_err++;
        add_run  = 0;
        in_wait  = 1'b1;
        wait_len = 0;
      end
      if (in_wait) begin
        if (s_ready || done) begin
          in_wait = 1'b0;
          if (!prev_wr) early_err++;
          if (wait_len != exp_wait) wait_len_err++;
        end else begin
          wait_len++;
          if (addr_write !== held_addr || din !== held_din) hold_err++;
        end
      end
      prev_wr = write_ready;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic clear_mem;
    mem_clear = 1'b1; tick(); mem_clear = 1'b0;
  endtask

  task automatic start_tile(input addr_t last, input pass_t passes);
    cfg_last_addr = last; cfg_passes = passes; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send_word(input word_t w, input int gap);
    int n;
    for (int g = 0; g < gap; g++) begin
      s_valid = 1'b0; s_data = word_t'({$urandom(), $urandom()}); tick();
    end
    s_valid = 1'b1; s_data = w; n = 0;
    while (!s_ready && n < 64) begin tick(); n++; end
    if (!s_ready) begin
      n_cmp++; n_bad++;
      $display("FAIL send_word: s_ready stayed 0 for %0d cycles, required 1", n);
      s_valid = 1'b0;
      return;
    end
    tick();
    s_valid = 1'b0; s_data = JUNK;
  endtask

  task automatic wait_done(output bit ok);
    int n = 0;
    while (!done && n < 100) begin tick(); n++; end
    ok = done;
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display("FAIL wait_done: done=0 after %0d cycles, required 1", n);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    logic [63:0] outs;
    #2;
    outs = {s_ready, ena_w, ena_add_write, addr_write, din, busy, pass_idx, done};
    n_cmp++;
    if (outs !== 64'd0) begin
      n_bad++; $display("FAIL reset_outputs: got %h, required 0", outs);
    end
    tick(); tick();
    rst = 1'b0;
    clear_mem();
  endtask

  task automatic test_single_pass;
    word_t w[3];
    int h0, p0, d0, a0, q0;
    bit ok;
    w[0] = {16'h4200, 16'h4000, 16'h3C00};
    w[1] = {16'h3C00, 16'h4200, 16'h4000};
    w[2] = {16'h4000, 16'h3C00, 16'h4200};
    last_exp = 2; exp_wait = 1;
    h0 = hs_cycs.size(); p0 = plain_cnt; d0 = done_cnt; a0 = addw_cnt; q0 = plain_addrs.size();
    start_tile(3'd2, 8'd1);
    for (int i = 0; i < 3; i++) send_word(w[i], 0);
    wait_done(ok);
    tick();
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (mem[i] !== w[i]) begin
        n_bad++; $display("FAIL single_mem[%0d]: got %h, required %h", i, mem[i], w[i]);
      end
    end
    n_cmp++;
    if (plain_cnt - p0 != 3 || addw_cnt - a0 != 0) begin
      n_bad++; $display("FAIL single_counts: plain=%0d addw=%0d, required 3 and 0", plain_cnt - p0, addw_cnt - a0);
    end
    n_cmp++;
    if (plain_addrs.size() - q0 != 3 || plain_addrs[q0] !== 3'd0 || plain_addrs[q0+1] !== 3'd1 || plain_addrs[q0+2] !== 3'd2) begin
      n_bad++; $display("FAIL single_addr_order: %0d writes, required addr 0,1,2", plain_addrs.size() - q0);
    end
    n_cmp++;
    if (hs_cycs.size() > h0 && done_cyc - hs_cycs[h0] != 6) begin
      n_bad++; $display("FAIL single_done_latency: got %0d cycles, required 6", done_cyc - hs_cycs[h0]);
    end
    n_cmp++;
    if (done_cnt - d0 != 1 || busy !== 1'b0) begin
      n_bad++; $display("FAIL single_done: pulses=%0d busy=%b, required 1 and 0", done_cnt - d0, busy);
    end
  endtask

  task automatic run_acc_tile(input bit gapped, output pass_t pass_at_done);
    bit ok;
    start_tile(3'd1, 8'd3);
    for (int i = 0; i < 6; i++) send_word(ONES, gapped ? int'($urandom_range(0, 3)) : 0);
    wait_done(ok);
    pass_at_done = pass_idx;
    repeat (3) tick();
  endtask

  task automatic test_multi_pass;
    int d0, r0, l0, p0, w0, e0, s0;
    pass_t pd;
    last_exp = 1; exp_wait = 1;
    clear_mem();
    d0 = done_cnt; r0 = add_runs; l0 = add_len_err; p0 = plain_cnt; w0 = wait_len_err; e0 = early_err; s0 = sready_err;
    run_acc_tile(1'b0, pd);
    for (int i = 0; i < 2; i++) begin
      n_cmp++;
      if (mem[i] !== THREES) begin
        n_bad++; $display("FAIL multi_mem[%0d]: got %h, required %h", i, mem[i], THREES);
      end
    end
    n_cmp++;
    if (add_runs - r0 != 4 || add_len_err != l0 || plain_cnt - p0 != 2) begin
      n_bad++; $display("FAIL multi_writes: adds=%0d bad_len=%0d plain=%0d, required 4, 0, 2", add_runs - r0, add_len_err - l0, plain_cnt - p0);
    end
    n_cmp++;
    if (done_cnt - d0 != 1 || pd !== 8'd2) begin
      n_bad++; $display("FAIL multi_done: pulses=%0d pass_idx=%0d, required 1 and 2", done_cnt - d0, pd);
    end
    n_cmp++;
    if (wait_len_err != w0 || early_err != e0 || sready_err != s0) begin
      n_bad++; $display("FAIL multi_protocol: wait_len=%0d early=%0d s_ready=%0d errors, required 0", wait_len_err - w0, early_err - e0, sready_err - s0);
    end
  endtask

  task automatic test_gapped;
    int d0, s0, l0;
    pass_t pd;
    last_exp = 1; exp_wait = 1;
    clear_mem();
    d0 = done_cnt; s0 = sready_err; l0 = add_len_err;
    run_acc_tile(1'b1, pd);
    for (int i = 0; i < 2; i++) begin
      n_cmp++;
      if (mem[i] !== THREES) begin
        n_bad++; $display("FAIL gapped_mem[%0d]: got %h, required %h", i, mem[i], THREES);
      end
    end
    n_cmp++;
    if (sready_err != s0 || add_len_err != l0 || done_cnt - d0 != 1) begin
      n_bad++; $display("FAIL gapped_protocol: s_ready=%0d len=%0d errors, done=%0d; required 0, 0, 1", sready_err - s0, add_len_err - l0, done_cnt - d0);
    end
  endtask

  task automatic test_slow_write_ready;
    int h0, e0, w0, r0;
    bit ok;
    pass_t pd;
    last_exp = 1; exp_wait = 6; wr_delay = 5;
    clear_mem();
    h0 = hold_err; e0 = early_err; w0 = wait_len_err; r0 = add_runs;
    start_tile(3'd1, 8'd2);
    for (int i = 0; i < 4; i++) send_word(ONES, 0);
    wait_done(ok);
    pd = pass_idx;
    tick();
    for (int i = 0; i < 2; i++) begin
      n_cmp++;
      if (mem[i] !== TWOS) begin
        n_bad++; $display("FAIL slow_mem[%0d]: got %h, required %h", i, mem[i], TWOS);
      end
    end
    n_cmp++;
    if (hold_err != h0) begin
      n_bad++; $display("FAIL slow_hold: %0d cycles with addr_write/din changed in wait, required 0", hold_err - h0);
    end
    n_cmp++;
    if (early_err != e0 || wait_len_err != w0 || add_runs - r0 != 2) begin
      n_bad++; $display("FAIL slow_wait: early=%0d len_err=%0d adds=%0d, required 0, 0, 2", early_err - e0, wait_len_err - w0, add_runs - r0);
    end
    n_cmp++;
    if (pd !== 8'd1) begin
      n_bad++; $display("FAIL slow_pass_idx: got %0d, required 1", pd);
    end
    wr_delay = 0; exp_wait = 1;
  endtask

  task automatic test_zero_passes;
    word_t w;
    int d0, p0, a0, k0;
    bit ok;
    w = {16'h4200, 16'h3C00, 16'h4000};
    last_exp = 0; exp_wait = 1;
    clear_mem();
    d0 = done_cnt; p0 = plain_cnt; a0 = addw_cnt; k0 = hs_cnt;
    start_tile(3'd0, 8'd0);
    n_cmp++;
    if (busy !== 1'b1) begin
      n_bad++; $display("FAIL zero_busy: got %b, required 1", busy);
    end
    start_tile(3'd5, 8'd4);
    send_word(w, 0);
    wait_done(ok);
    start = 1'b1; cfg_last_addr = 3'd2; cfg_passes = 8'd2;
    tick();
    start = 1'b0;
    repeat (2) tick();
    n_cmp++;
    if (busy !== 1'b0 || s_ready !== 1'b0) begin
      n_bad++; $display("FAIL zero_start_at_done: busy=%b s_ready=%b, required 0 and 0", busy, s_ready);
    end
    n_cmp++;
    if (mem[0] !== w || plain_cnt - p0 != 1 || addw_cnt - a0 != 0) begin
      n_bad++; $display("FAIL zero_write: mem=%h plain=%0d addw=%0d, required %h, 1, 0", mem[0], plain_cnt - p0, addw_cnt - a0, w);
    end
    n_cmp++;
    if (done_cnt - d0 != 1 || hs_cnt - k0 != 1) begin
      n_bad++; $display("FAIL zero_done: pulses=%0d handshakes=%0d, required 1 and 1", done_cnt - d0, hs_cnt - k0);
    end
  endtask

  task automatic test_reset_mid_add;
    logic [63:0] outs;
    int d0, r0, l0;
    bit ok;
    pass_t pd;
    last_exp = 1; exp_wait = 6; wr_delay = 5;
    start_tile(3'd1, 8'd2);
    for (int i = 0; i < 3; i++) send_word(ONES, 0);
    repeat (3) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    outs = {s_ready, ena_w, ena_add_write, addr_write, din, busy, pass_idx, done};
    n_cmp++;
    if (outs !== 64'd0) begin
      n_bad++; $display("FAIL midreset_outputs: got %h, required 0", outs);
    end
    repeat (2) tick();
    rst = 1'b0;
    wr_delay = 0; exp_wait = 1; last_exp = 0;
    clear_mem();
    d0 = done_cnt; r0 = add_runs; l0 = add_len_err;
    start_tile(3'd0, 8'd2);
    n_cmp++;
    if (busy !== 1'b1) begin
      n_bad++; $display("FAIL midreset_restart_busy: got %b, required 1", busy);
    end
    send_word(ONES, 0);
    send_word(ONES, 0);
    wait_done(ok);
    pd = pass_idx;
    tick();
    n_cmp++;
    if (mem[0] !== TWOS || pd !== 8'd1) begin
      n_bad++; $display("FAIL midreset_clean_tile: mem=%h pass_idx=%0d, required %h and 1", mem[0], pd, TWOS);
    end
    n_cmp++;
    if (done_cnt - d0 != 1 || add_runs - r0 != 1 || add_len_err != l0) begin
      n_bad++; $display("FAIL midreset_counts: done=%0d adds=%0d len_err=%0d, required 1, 1, 0", done_cnt - d0, add_runs - r0, add_len_err - l0);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; cfg_last_addr = '0; cfg_passes = '0;
    s_valid = 1'b0; s_data = '0; mem_clear = 1'b0; wr_delay = 0;
    test_reset();
    test_single_pass();
    test_multi_pass();
    test_gapped();
    test_slow_write_ready();
    test_zero_passes();
    test_reset_mid_add();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
